// File: rtl/bhg_pkg.sv
// Shared types and widths for the bhargava key-schedule controller.
package bhg_pkg;

  localparam int KEY_W  = 64;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_PASS,
    ST_DRAIN
  } bhg_state_e;

endpackage

// File: rtl/bhg_inflight_cnt.sv
// Saturating up/down count of bytes issued to the core but not yet seen at its output.
module bhg_inflight_cnt #(
  parameter int IFL_W = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_zero
);

  localparam logic [IFL_W-1:0] CNT_MAX = '1;
  localparam logic [IFL_W-1:0] CNT_ONE = IFL_W'(1);

  logic [IFL_W-1:0] r_cnt;

  // Simultaneous inc and dec cancel; both ends clamp instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (i_inc && !i_dec && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else if (!i_inc && i_dec && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_ONE;
      end
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/bhg_key_sched_ctrl.sv
// Feeds MPEG bytes into the bhargava core and sequences safe key/mode changes.
// Optional BHG_KEY_SCHED_STATS_EN adds byte/full-cycle statistics counters.
//
// state     | meaning
// ST_LOAD   | one cycle, key_en issued to the core
// ST_SETTLE | key schedule settling, input held off
// ST_PASS   | bytes flow from source to core
// ST_DRAIN  | waiting for in-flight bytes to leave the core
module bhg_key_sched_ctrl
  import bhg_pkg::*;
#(
  parameter int               IFL_W      = 24,
  parameter int               DRAIN_TO   = 4096,
  parameter int               SETTLE_CYC = 20,
  parameter logic [KEY_W-1:0] KEY_RST    = 64'h0,
  parameter logic             MODE_RST   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [BYTE_W-1:0] src_data,
  input  logic              src_valid,
  input  logic              src_last,
  output logic              src_ready,
  output logic [BYTE_W-1:0] mpeg_in,
  output logic              mpeg_in_en,
  output logic              stream_end,
  input  logic              mpeg_prog_full,
  input  logic              mpeg_out_en,
  input  logic              key_req,
  input  logic [KEY_W-1:0]  key_new,
  input  logic              mode_new,
  output logic              key_ack,
  output logic              key_late,
  output logic [KEY_W-1:0]  key_in,
  output logic              mode_in,
  output logic              key_en,
  output logic              busy
`ifdef BHG_KEY_SCHED_STATS_EN
  ,
  output logic [31:0]       in_byte_cnt,
  output logic [31:0]       out_byte_cnt,
  output logic [31:0]       full_cycle_cnt
`endif
);

  localparam int TMR_MAX = (DRAIN_TO > SETTLE_CYC) ? DRAIN_TO : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] DRAIN_LD  = TMR_W'(DRAIN_TO - 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

  bhg_state_e        r_state;
  bhg_state_e        w_state_nxt;
  logic [TMR_W-1:0]  r_tmr;
  logic [TMR_W-1:0]  w_tmr_nxt;
  logic              r_post_rst;
  logic              w_key_acc;
  logic              w_force;
  logic              w_ack_nxt;
  logic              w_accept;
  logic              w_ifl_zero;

  logic [BYTE_W-1:0] r_mpeg_in;
  logic              r_mpeg_in_en;
  logic              r_stream_end;
  logic              r_key_ack;
  logic              r_key_late;
  logic [KEY_W-1:0]  r_key_in;
  logic              r_mode_in;
  logic              r_key_en;

  bhg_inflight_cnt #(
    .IFL_W (IFL_W)
  ) u_inflight (
    .clk    (clk),
    .rst    (rst),
    .i_en   (clk_en),
    .i_inc  (r_mpeg_in_en),
    .i_dec  (mpeg_out_en),
    .o_zero (w_ifl_zero)
  );

  // A single down-counter serves both the settle wait and the drain timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_key_acc   = 1'b0;
    w_force     = 1'b0;
    w_ack_nxt   = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_state_nxt = ST_SETTLE;
        w_tmr_nxt   = SETTLE_LD;
      end
      ST_SETTLE: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_PASS;
          w_ack_nxt   = ~r_post_rst;
        end else begin
          w_tmr_nxt = r_tmr - TMR_ONE;
        end
      end
      ST_PASS: begin
        if (key_req) begin
          w_key_acc   = 1'b1;
          w_state_nxt = ST_DRAIN;
          w_tmr_nxt   = DRAIN_LD;
        end
      end
      ST_DRAIN: begin
        if (w_ifl_zero) begin
          w_state_nxt = ST_LOAD;
        end else if (r_tmr == '0) begin
          w_state_nxt = ST_LOAD;
          w_force     = 1'b1;
        end else begin
          w_tmr_nxt = r_tmr - TMR_ONE;
        end
      end
      default: w_state_nxt = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_tmr   <= '0;
    end else if (clk_en) begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  assign src_ready = clk_en & (r_state == ST_PASS) & ~mpeg_prog_full
                     & ~r_stream_end & ~key_req;
  assign w_accept  = src_valid & src_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_post_rst   <= 1'b1;
      r_mpeg_in    <= '0;
      r_mpeg_in_en <= 1'b0;
      r_stream_end <= 1'b0;
      r_key_ack    <= 1'b0;
      r_key_late   <= 1'b0;
      r_key_in     <= KEY_RST;
      r_mode_in    <= MODE_RST;
      r_key_en     <= 1'b0;
    end else if (clk_en) begin
      r_key_en     <= (r_state == ST_LOAD);
      r_key_ack    <= w_ack_nxt;
      r_mpeg_in_en <= w_accept;
      if (w_accept) begin
        r_mpeg_in <= src_data;
      end
      if (w_accept && src_last) begin
        r_stream_end <= 1'b1;
      end
      if (w_key_acc) begin
        r_key_in   <= key_new;
        r_mode_in  <= mode_new;
        r_key_late <= 1'b0;
      end
      if (w_force) begin
        r_key_late <= 1'b1;
      end
      // Only the very first load after reset completes without acknowledging.
      if ((r_state == ST_SETTLE) && (w_state_nxt == ST_PASS)) begin
        r_post_rst <= 1'b0;
      end
    end
  end

  assign mpeg_in    = r_mpeg_in;
  assign mpeg_in_en = r_mpeg_in_en;
  assign stream_end = r_stream_end;
  assign key_ack    = r_key_ack;
  assign key_late   = r_key_late;
  assign key_in     = r_key_in;
  assign mode_in    = r_mode_in;
  assign key_en     = r_key_en;
  assign busy       = (r_state != ST_PASS);

`ifdef BHG_KEY_SCHED_STATS_EN
  logic [31:0] r_in_byte_cnt;
  logic [31:0] r_out_byte_cnt;
  logic [31:0] r_full_cycle_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_byte_cnt    <= '0;
      r_out_byte_cnt   <= '0;
      r_full_cycle_cnt <= '0;
    end else if (clk_en) begin
      if (w_accept)       r_in_byte_cnt    <= r_in_byte_cnt + 32'd1;
      if (mpeg_out_en)    r_out_byte_cnt   <= r_out_byte_cnt + 32'd1;
      if (mpeg_prog_full) r_full_cycle_cnt <= r_full_cycle_cnt + 32'd1;
    end
  end

  assign in_byte_cnt    = r_in_byte_cnt;
  assign out_byte_cnt   = r_out_byte_cnt;
  assign full_cycle_cnt = r_full_cycle_cnt;
`endif

endmodule

// File: tb/tb_bhg_key_sched_ctrl.sv
// Directed/randomized bench for bhg_key_sched_ctrl with a scoreboard reference.
module tb_bhg_key_sched_ctrl;

  localparam int          IFL_W      = 24;
  localparam int          DRAIN_TO   = 4096;
  localparam int          SETTLE_CYC = 20;
  localparam logic [63:0] KEY_RST    = 64'h0123_4567_89ab_cdef;
  localparam logic        MODE_RST   = 1'b1;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic [7:0]  src_data;
  logic        src_valid;
  logic        src_last;
  logic        src_ready;
  logic [7:0]  mpeg_in;
  logic        mpeg_in_en;
  logic        stream_end;
  logic        mpeg_prog_full;
  logic        mpeg_out_en;
  logic        key_req;
  logic [63:0] key_new;
  logic        mode_new;
  logic        key_ack;
  logic        key_late;
  logic [63:0] key_in;
  logic        mode_in;
  logic        key_en;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  bhg_key_sched_ctrl #(
    .IFL_W      (IFL_W),
    .DRAIN_TO   (DRAIN_TO),
    .SETTLE_CYC (SETTLE_CYC),
    .KEY_RST    (KEY_RST),
    .MODE_RST   (MODE_RST)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .src_data       (src_data),
    .src_valid      (src_valid),
    .src_last       (src_last),
    .src_ready      (src_ready),
    .mpeg_in        (mpeg_in),
    .mpeg_in_en     (mpeg_in_en),
    .stream_end     (stream_end),
    .mpeg_prog_full (mpeg_prog_full),
    .mpeg_out_en    (mpeg_out_en),
    .key_req        (key_req),
    .key_new        (key_new),
    .mode_new       (mode_new),
    .key_ack        (key_ack),
    .key_late       (key_late),
    .key_in         (key_in),
    .mode_in        (mode_in),
    .key_en         (key_en),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".src_ready"},  64'(src_ready),  64'd0);
    chk({tag, ".mpeg_in"},    64'(mpeg_in),    64'd0);
    chk({tag, ".mpeg_in_en"}, 64'(mpeg_in_en), 64'd0);
    chk({tag, ".stream_end"}, 64'(stream_end), 64'd0);
    chk({tag, ".key_ack"},    64'(key_ack),    64'd0);
    chk({tag, ".key_late"},   64'(key_late),   64'd0);
    chk({tag, ".key_in"},     key_in,          KEY_RST);
    chk({tag, ".mode_in"},    64'(mode_in),    64'(MODE_RST));
    chk({tag, ".key_en"},     64'(key_en),     64'd0);
    chk({tag, ".busy"},       64'(busy),       64'd1);
  endtask

  // Called with rst high at posedge+1; releases it and follows the automatic load.
  task automatic post_reset_check(input string tag);
    int n;
    rst = 1'b0;
    tick();
    n = 1;
    chk({tag, ".key_en_pulse"}, 64'(key_en), 64'd1);
    chk({tag, ".key_in_rst"},   key_in,      KEY_RST);
    while (src_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (n == 2) chk({tag, ".key_en_drop"}, 64'(key_en), 64'd0);
      chk({tag, ".no_key_ack"}, 64'(key_ack), 64'd0);
    end
    chk({tag, ".ready_delay"}, 64'(n), 64'(SETTLE_CYC + 1));
  endtask

  task automatic wait_key_en(input string tag, input int bound, output int n);
    n = 0;
    while (key_en !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk({tag, ".key_en_seen"}, 64'(key_en), 64'd1);
  endtask

  // Entered right after key_en was observed; releases key_req on key_ack.
  task automatic settle_and_ack(input string tag, input logic exp_late);
    for (int i = 1; i < SETTLE_CYC; i++) begin
      tick();
      chk({tag, ".ack_early"}, 64'(key_ack), 64'd0);
      chk({tag, ".busy_settle"}, 64'(busy), 64'd1);
    end
    tick();
    chk({tag, ".key_ack"},  64'(key_ack),  64'd1);
    chk({tag, ".busy_end"}, 64'(busy),     64'd0);
    chk({tag, ".key_late"}, 64'(key_late), 64'(exp_late));
    key_req = 1'b0;
    tick();
    chk({tag, ".ack_once"}, 64'(key_ack), 64'd0);
  endtask

  // Reference: a byte is taken iff valid and not full; it appears one cycle later in order.
  task automatic stream(input string tag, input int n_bytes, input bit use_full, input bit echo);
    logic [7:0] exp_q[$];
    logic       exp_en;
    logic       acc;
    logic       full;
    int         got;
    int         seen;
    int         c;
    exp_en = 1'b0;
    got    = 0;
    seen   = 0;
    c      = 0;
    while (got < n_bytes && c < 20 * n_bytes + 100) begin
      full           = use_full && ((c % 8) < 3);
      mpeg_prog_full = full;
      src_valid      = ($urandom_range(3) != 0);
      src_data       = 8'($urandom);
      src_last       = 1'b0;
      mpeg_out_en    = echo && exp_en;
      #1;
      acc = src_valid && !full;
      chk({tag, ".src_ready"}, 64'(src_ready), 64'(!full));
      if (acc) begin
        exp_q.push_back(src_data);
        got++;
      end
      tick();
      chk({tag, ".mpeg_in_en"}, 64'(mpeg_in_en), 64'(acc));
      if (mpeg_in_en === 1'b1) begin
        seen++;
        if (exp_q.size() != 0) chk({tag, ".mpeg_in"}, 64'(mpeg_in), 64'(exp_q.pop_front()));
      end
      exp_en = acc;
      c++;
    end
    src_valid      = 1'b0;
    mpeg_prog_full = 1'b0;
    mpeg_out_en    = echo && exp_en;
    tick();
    mpeg_out_en    = 1'b0;
    chk({tag, ".strobes"}, 64'(seen), 64'(n_bytes));
  endtask

  initial begin
    int          n;
    logic [63:0] k;
    rst            = 1'b1;
    clk_en         = 1'b1;
    src_data       = '0;
    src_valid      = 1'b0;
    src_last       = 1'b0;
    mpeg_prog_full = 1'b0;
    mpeg_out_en    = 1'b0;
    key_req        = 1'b0;
    key_new        = '0;
    mode_new       = 1'b0;

    // 1: reset values and automatic post-reset load
    tick();
    tick();
    check_reset_vals("t1");
    post_reset_check("t1");

    // 2: long stream with 3-on/5-off back-pressure, core echoes every byte
    stream("t2", 1000, 1'b1, 1'b1);

    // 3: key change with 10 bytes in flight, drained by the core
    stream("t3s", 10, 1'b0, 1'b0);
    key_req   = 1'b1;
    key_new   = 64'ha1b2c3d4e5f61234;
    mode_new  = 1'b0;
    src_valid = 1'b1;
    #1;
    chk("t3.ready_on_req", 64'(src_ready), 64'd0);
    tick();
    src_valid = 1'b0;
    chk("t3.busy",       64'(busy),       64'd1);
    chk("t3.no_byte",    64'(mpeg_in_en), 64'd0);
    chk("t3.key_in",     key_in,          64'ha1b2c3d4e5f61234);
    chk("t3.mode_in",    64'(mode_in),    64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3.hold_drain", 64'(key_en), 64'd0);
    end
    mpeg_out_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3.early_load", 64'(key_en), 64'd0);
    end
    mpeg_out_en = 1'b0;
    tick();
    chk("t3.load_cycle", 64'(key_en), 64'd0);
    tick();
    chk("t3.key_en", 64'(key_en), 64'd1);
    settle_and_ack("t3", 1'b0);

    // 4: core never drains -> forced load after the timeout
    stream("t4s", 3, 1'b0, 1'b0);
    k        = {$urandom, $urandom};
    key_req  = 1'b1;
    key_new  = k;
    mode_new = 1'b1;
    tick();
    chk("t4.busy", 64'(busy), 64'd1);
    chk("t4.late_clear", 64'(key_late), 64'd0);
    wait_key_en("t4", 2 * DRAIN_TO + 10, n);
    chk("t4.drain_len", 64'(n), 64'(DRAIN_TO + 1));
    chk("t4.key_late", 64'(key_late), 64'd1);
    chk("t4.key_in",   key_in,        k);
    settle_and_ack("t4", 1'b1);
    chk("t4.late_sticky", 64'(key_late), 64'd1);

    // 4b: next accepted request clears key_late; core drains the 3 stuck bytes
    k        = {$urandom, $urandom};
    key_req  = 1'b1;
    key_new  = k;
    mode_new = 1'b0;
    tick();
    chk("t4b.late_clear", 64'(key_late), 64'd0);
    mpeg_out_en = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    mpeg_out_en = 1'b0;
    wait_key_en("t4b", 50, n);
    chk("t4b.key_in", key_in, k);
    settle_and_ack("t4b", 1'b0);

    // clock enable low: everything holds, no byte accepted
    src_valid = 1'b1;
    src_data  = 8'h5a;
    #1;
    tick();
    chk("ce.byte", 64'(mpeg_in), 64'h5a);
    clk_en   = 1'b0;
    src_data = 8'h11;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ce.ready", 64'(src_ready), 64'd0);
      tick();
      chk("ce.en_hold",  64'(mpeg_in_en), 64'd1);
      chk("ce.in_hold",  64'(mpeg_in),    64'h5a);
    end
    src_valid = 1'b0;
    clk_en    = 1'b1;
    tick();
    chk("ce.resume", 64'(mpeg_in_en), 64'd0);

    // 5: src_last on the 7th byte
    for (int i = 1; i <= 7; i++) begin
      src_valid = 1'b1;
      src_data  = 8'(i * 13);
      src_last  = (i == 7);
      #1;
      chk("t5.ready", 64'(src_ready), 64'd1);
      tick();
      chk("t5.en",         64'(mpeg_in_en), 64'd1);
      chk("t5.data",       64'(mpeg_in),    64'(i * 13));
      chk("t5.stream_end", 64'(stream_end), 64'(i == 7));
    end
    src_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5.ready_after", 64'(src_ready), 64'd0);
      tick();
      chk("t5.no_byte", 64'(mpeg_in_en), 64'd0);
      chk("t5.sticky",  64'(stream_end), 64'd1);
    end
    src_valid = 1'b0;

    // 6: key_req after stream_end is honoured; reset mid-drain and mid-settle
    k       = {$urandom, $urandom};
    key_req = 1'b1;
    key_new = k;
    tick();
    chk("t6.busy",   64'(busy), 64'd1);
    chk("t6.key_in", key_in,    k);
    rst = 1'b1;
    #1;
    check_reset_vals("t6a");
    key_req = 1'b0;
    tick();
    post_reset_check("t6a");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t6.key_en_pre", 64'(key_en), 64'd1);
    rst = 1'b1;
    #1;
    check_reset_vals("t6b");
    tick();
    post_reset_check("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
